// File: rtl/aes_cipher_iter.sv
// Iterative AES forward cipher: one full round per clock on a single 128-bit state register,
// driven by a pre-expanded key schedule, with valid/ready handshakes on input and output.
module aes_cipher_iter #(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [127:0]          plaintext,
    input  logic [128*(Nr+1)-1:0] expanded_key,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [127:0]          ciphertext
);

    localparam int         KEY_W      = 128 * (Nr + 1);
    localparam logic [3:0] LAST_ROUND = 4'(Nr);
    // A schedule whose size disagrees with the key length is refused outright.
    localparam logic       CFG_OK     = (Nr == Nk + 6);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state, state_next;
    logic [3:0]   round;
    logic [127:0] state_reg;
    logic [127:0] rk0, rk_cur, sr_out, round_out, final_out;
    logic         accept;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
        return o;
    endfunction

    // Byte (row r, column c) lives at index 4*c+r, counted from the MSB end.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    assign rk0       = expanded_key[KEY_W-1 -: 128];
    assign rk_cur    = expanded_key[KEY_W-1-128*int'(round) -: 128];
    assign sr_out    = shift_rows(sub_bytes(state_reg));
    assign round_out = mix_columns(sr_out) ^ rk_cur;
    assign final_out = sr_out ^ rk_cur;

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    // in_ready is 1 only in IDLE; out_valid is 1 only in DONE and holds until out_ready.
    assign accept = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = BUSY;
            BUSY:    if (round == LAST_ROUND) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) & CFG_OK;
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            round      <= '0;
            state_reg  <= '0;
            ciphertext <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    state_reg <= plaintext ^ rk0;
                    round     <= 4'd1;
                end
                BUSY: if (round == LAST_ROUND) begin
                    ciphertext <= final_out;
                end else begin
                    state_reg <= round_out;
                    round     <= round + 4'd1;
                end
                DONE: if (out_ready) round <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Directed bench for aes_cipher_iter: FIPS-197 / SP800-38A vectors, handshake stalls,
// mid-block reset, and an AES-256 build. Key schedules come from a reference expansion here.
module tb_aes_cipher_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic               a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [127:0]       a_pt, a_ct;
    logic [128*11-1:0]  a_key;
    logic               b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [127:0]       b_pt, b_ct;
    logic [128*15-1:0]  b_key;

    int checks = 0;
    int errors = 0;

    aes_cipher_iter #(.Nk(4), .Nr(10)) dut10 (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .plaintext(a_pt), .expanded_key(a_key), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .ciphertext(a_ct)
    );

    aes_cipher_iter #(.Nk(8), .Nr(14)) dut14 (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .plaintext(b_pt), .expanded_key(b_key), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .ciphertext(b_ct)
    );

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference S-box from first principles: GF(2^8) inverse then the affine map.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v};
        return d[15-n -: 8];
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gf_mul(inv, x);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_ref(w[31:24]), sbox_ref(w[23:16]), sbox_ref(w[15:8]), sbox_ref(w[7:0])};
    endfunction

    function automatic logic [32*60-1:0] expand(input logic [255:0] key, input int nk, input int nr);
        logic [31:0]        w[60];
        logic [31:0]        t;
        logic [7:0]         rc;
        logic [32*60-1:0]   flat;
        rc   = 8'h01;
        flat = '0;
        for (int i = 0; i < 60; i++) w[i] = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gf_mul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int i = 0; i < 4*(nr+1); i++) flat[32*60-1-32*i -: 32] = w[i];
        return flat;
    endfunction

    task automatic load_key10(input logic [127:0] k);
        logic [32*60-1:0] f;
        f     = expand({k, 128'h0}, 4, 10);
        a_key = f[1919 -: 1408];
    endtask

    task automatic accept_a(input logic [127:0] pt, input bit keep, input string name);
        int n;
        n          = 0;
        a_pt       = pt;
        a_in_valid = 1'b1;
        while (!a_in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, " in_ready before accept"}, a_in_ready, 1'b1);
        @(posedge clk); #1;
        if (!keep) a_in_valid = 1'b0;
    endtask

    task automatic wait_out_a(output int lat);
        lat = 0;
        while (!a_out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic drain_a();
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
    endtask

    initial begin
        int lat, bad;
        logic [32*60-1:0] f;

        vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                    128'h3925841d02dc09fbdc118597196a0b32};
        vecs[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h6bc1bee22e409f96e93d7e117393172a,
                    128'h3ad77bb40d7a3660a89ecaf32466ef97};
        vecs[3] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
                    128'hf5d3d58503b9699de785895a96fdbaaf};

        rst_n = 1'b0;
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_pt = '0; a_key = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_pt = '0; b_key = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset out_valid", a_out_valid, 1'b0);
        check("reset ciphertext", a_ct, 128'h0);
        check("reset in_ready", a_in_ready, 1'b1);
        check("reset out_valid nr14", b_out_valid, 1'b0);
        check("reset in_ready nr14", b_in_ready, 1'b1);

        // Table vectors, out_ready held high throughout (including while idle/busy).
        for (int i = 0; i < 4; i++) begin
            load_key10(vecs[i].key);
            a_out_ready = 1'b1;
            accept_a(vecs[i].pt, 1'b0, $sformatf("vec%0d", i));
            check($sformatf("vec%0d out_valid before done", i), a_out_valid, 1'b0);
            wait_out_a(lat);
            check($sformatf("vec%0d latency", i), lat, 10);
            check($sformatf("vec%0d ciphertext", i), a_ct, vecs[i].ct);
            @(posedge clk); #1;
            check($sformatf("vec%0d out_valid after drain", i), a_out_valid, 1'b0);
            check($sformatf("vec%0d in_ready after drain", i), a_in_ready, 1'b1);
            a_out_ready = 1'b0;
        end

        // Backpressure: 20 stalled cycles with a new block offered, then a one-cycle drain.
        load_key10(vecs[1].key);
        accept_a(vecs[1].pt, 1'b0, "stall");
        wait_out_a(lat);
        check("stall latency", lat, 10);
        a_pt       = vecs[2].pt;
        a_in_valid = 1'b1;
        bad        = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (!a_out_valid || a_ct !== vecs[1].ct || a_in_ready) bad++;
        end
        check("stall unstable cycles", bad, 0);
        check("stall ciphertext", a_ct, vecs[1].ct);
        drain_a();
        check("stall drain out_valid", a_out_valid, 1'b0);
        check("stall drain in_ready", a_in_ready, 1'b1);
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        check("stall next accepted", a_in_ready, 1'b0);
        wait_out_a(lat);
        check("stall next latency", lat, 10);
        check("stall next ciphertext", a_ct, vecs[2].ct);
        drain_a();

        // in_valid held during BUSY with a different plaintext must be ignored.
        load_key10(vecs[0].key);
        accept_a(vecs[0].pt, 1'b1, "busy_ignore");
        a_pt = vecs[1].pt;
        lat  = 0;
        bad  = 0;
        while (!a_out_valid && lat < 40) begin
            if (a_in_ready) bad++;
            @(posedge clk); #1;
            lat++;
        end
        check("busy_ignore in_ready during busy", bad, 0);
        check("busy_ignore latency", lat, 10);
        check("busy_ignore first ciphertext", a_ct, vecs[0].ct);
        load_key10(vecs[1].key);
        check("busy_ignore in_ready in done", a_in_ready, 1'b0);
        drain_a();
        check("busy_ignore idle after drain", a_in_ready, 1'b1);
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        check("busy_ignore second accepted", a_in_ready, 1'b0);
        wait_out_a(lat);
        check("busy_ignore second latency", lat, 10);
        check("busy_ignore second ciphertext", a_ct, vecs[1].ct);
        drain_a();

        // Asynchronous reset while round counter reads 5.
        load_key10(vecs[0].key);
        accept_a(vecs[0].pt, 1'b0, "midreset");
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midreset out_valid", a_out_valid, 1'b0);
        check("midreset ciphertext", a_ct, 128'h0);
        check("midreset in_ready", a_in_ready, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        a_out_ready = 1'b1;
        accept_a(vecs[0].pt, 1'b0, "postreset");
        wait_out_a(lat);
        check("postreset latency", lat, 10);
        check("postreset ciphertext", a_ct, vecs[0].ct);
        @(posedge clk); #1;
        a_out_ready = 1'b0;

        // AES-256 build, FIPS-197 C.3.
        f           = expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
        b_key       = f;
        b_pt        = 128'h00112233445566778899aabbccddeeff;
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        check("nr14 in_ready before accept", b_in_ready, 1'b1);
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        lat = 0;
        while (!b_out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("nr14 latency", lat, 14);
        check("nr14 ciphertext", b_ct, 128'h8ea2b7ca516745bfeafc49904b496089);
        @(posedge clk); #1;
        check("nr14 out_valid after drain", b_out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
